updown_sweep_ctrl: RTL and testbench
====================================

# updown_sweep_ctrl

Sequencer for the team's 4-bit `up_down_counter`: drives its `enable`/`up_down` inputs so the count sweeps ping-pong between programmable bounds `lo` and `hi`, dwelling `hold` cycles at each endpoint, for `n_sweeps` round trips or continuously. It sits beside the counter, observes the live count, and gives a host start/stop control with busy/done status.

## Interface
- `WIDTH`, 4: counter width, matches `up_down_counter`
- `HOLD_W`, 4: width of the dwell setting
- `SWEEP_W`, 8: width of the sweep count and limit
- `clk` in 1: clock, all state updates on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle request; latches configuration when idle
- `stop` in 1: abort request, level-sampled
- `lo` in WIDTH: lower sweep bound
- `hi` in WIDTH: upper sweep bound
- `hold` in HOLD_W: dwell cycles at each endpoint; 0 = no dwell
- `n_sweeps` in SWEEP_W: round trips to run; 0 = run until `stop`
- `cnt_value` in WIDTH: current `count` from the counter
- `cnt_enable` out 1: to counter `enable`
- `cnt_up_down` out 1: to counter `up_down`; 1 = up
- `busy` out 1: high whenever state is not IDLE
- `done` out 1: one-cycle pulse on normal completion
- `cfg_err` out 1: one-cycle pulse when `start` is rejected
- `sweep_cnt` out SWEEP_W: completed round trips since the last accepted start

## Operation
- States are IDLE, SEEK, UP, HOLD_HI, DOWN, and HOLD_LO.
- IDLE, `start`=1, `stop`=0:
  - `lo < hi`: latch `lo`/`hi`/`hold`/`n_sweeps`, clear `sweep_cnt`, go to SEEK.
  - Otherwise: pulse `cfg_err`, stay in IDLE.
- SEEK:
  - Counting: `cnt_enable`=1, with `cnt_up_down` = (`cnt_value` < lo).
  - When `cnt_value`==lo: `cnt_enable`=0, go to UP.
- UP:
  - Counting: `cnt_enable`=1, `cnt_up_down`=1.
  - When `cnt_value`==hi: `cnt_enable`=0, go to HOLD_HI, or to DOWN if `hold`==0.
- HOLD_HI: `cnt_enable`=0, `cnt_up_down`=0. Stay exactly `hold` cycles, then go to DOWN.
- DOWN:
  - Counting: `cnt_enable`=1, `cnt_up_down`=0.
  - When `cnt_value`==lo: `cnt_enable`=0 and `sweep_cnt` increments.
    - If `n_sweeps`≠0 and the new `sweep_cnt`==`n_sweeps`: go to IDLE and pulse `done`.
    - Otherwise: go to HOLD_LO, or to UP if `hold`==0.
- HOLD_LO: `cnt_enable`=0, `cnt_up_down`=1. Stay `hold` cycles, then go to UP.
- IDLE outputs: `cnt_enable`=0, `cnt_up_down`=1.
- `stop`=1 in any non-IDLE state:
  - `cnt_enable` is forced to 0 in that same cycle.
  - Next state is IDLE; no `done` pulse; `sweep_cnt` is held.
- `start` while busy: ignored. `start` and `stop` together in IDLE: `stop` wins, no state change, no `cfg_err`.
- `sweep_cnt` saturates at all-ones when `n_sweeps`=0.
- `reset_n` low, including mid-sweep, immediately gives:
  - state IDLE, `sweep_cnt`=0, dwell timer 0
  - `busy`=0, `done`=0, `cfg_err`=0, `cnt_enable`=0, `cnt_up_down`=1

## Timing
- `cnt_enable` and `cnt_up_down` are combinational from state, `cnt_value`, and `stop`. The counter therefore stops exactly on `lo`/`hi` and never overshoots.
- `busy`, `done`, `cfg_err`, and `sweep_cnt` are registered.
  - `busy` rises the cycle after an accepted `start`.
  - `done` and the IDLE entry happen on the same edge.
- Each endpoint costs one non-counting cycle in SEEK/UP/DOWN, so the steady-state period is 2·(hi−lo+1) + 2·hold cycles.
- The counter is assumed to update on the same `clk` edge with a single-cycle response.

## Structure
- Package `updown_sweep_pkg` holds:
  - the state enum (IDLE..HOLD_LO)
  - default parameter constants (`WIDTH`=4, `HOLD_W`=4, `SWEEP_W`=8)
- Sub-module `sweep_hold_timer`: a loadable HOLD_W down-counter with a `zero` flag, used by both HOLD states.
- The counter is external; the bench instantiates `up_down_counter` and cross-connects it.

## Test plan
- Counter reset to 0; start with lo=2, hi=5, hold=1, n_sweeps=2:
  - SEEK takes 3 cycles.
  - Count sequence: 2,3,4,5,5,5,4,3,2,2,2,3…
  - `done` pulses once after the second return to 2.
  - `sweep_cnt`=2, `busy` falls on the same edge.
- lo=0, hi=15, hold=0, n_sweeps=1:
  - Counts 0→15→0 with no wrap to 0/15 beyond the bounds.
  - Period is 32 cycles.
- Start with lo=7, hi=7 → `cfg_err` one-cycle pulse, `busy` stays 0. Start with lo=9, hi=3 → same response.
- n_sweeps=0, lo=1, hi=4: runs past 3 round trips; `stop` asserted mid-UP at count 3:
  - `cnt_enable` is 0 that cycle and the count holds at 3.
  - IDLE next edge, no `done`, `sweep_cnt`=3.
- `reset_n` pulsed low mid-DOWN at count 4 → outputs immediately at reset values, state IDLE. Then `start` with `stop` high in the same cycle → still IDLE, no `cfg_err`.
- Counter at 12 with lo=3, hi=6 → SEEK counts down 12→3 (`cnt_up_down`=0) before the first UP.

Source files
------------

// File: rtl/updown_sweep_pkg.sv
// Shared types and default widths for the up/down sweep sequencer.
package updown_sweep_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_HOLD_W  = 4;
  localparam int DEF_SWEEP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEEK    = 3'd1,
    ST_UP      = 3'd2,
    ST_HOLD_HI = 3'd3,
    ST_DOWN    = 3'd4,
    ST_HOLD_LO = 3'd5
  } sweep_state_e;

endpackage

// File: rtl/sweep_hold_timer.sv
// Loadable down-counter timing the dwell at each sweep endpoint.
module sweep_hold_timer #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [HOLD_W-1:0] tmr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr <= '0;
    end else if (load) begin
      tmr <= load_val;
    end else if (dec && (tmr != '0)) begin
      tmr <= tmr - HOLD_W'(1);
    end
  end

  assign zero = (tmr == '0);

endmodule

// File: rtl/up_down_counter.sv
// Plain wrapping up/down counter driven by the sweep sequencer.
module up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (enable) begin
      count <= up_down ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Ping-pong sweep sequencer: steers an external up/down counter between lo and hi.
// state      | meaning
// IDLE       | waiting for start, counter parked
// SEEK       | moving counter onto lo before the first sweep
// UP         | counting up toward hi
// HOLD_HI    | dwelling at hi for hold cycles
// DOWN       | counting down toward lo; a round trip completes at lo
// HOLD_LO    | dwelling at lo for hold cycles
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HOLD_W  = DEF_HOLD_W,
  parameter int SWEEP_W = DEF_SWEEP_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [HOLD_W-1:0]  hold,
  input  logic [SWEEP_W-1:0] n_sweeps,
  input  logic [WIDTH-1:0]   cnt_value,
  output logic               cnt_enable,
  output logic               cnt_up_down,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  sweep_state_e       state;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   hi_r;
  logic [HOLD_W-1:0]  hold_r;
  logic [SWEEP_W-1:0] n_sweeps_r;

  logic               at_lo;
  logic               at_hi;
  logic               tmr_load;
  logic               tmr_dec;
  logic               tmr_zero;
  logic [SWEEP_W-1:0] sweep_next;

  assign at_lo      = (cnt_value == lo_r);
  assign at_hi      = (cnt_value == hi_r);
  assign sweep_next = (sweep_cnt == '1) ? sweep_cnt : sweep_cnt + SWEEP_W'(1);

  // Counter controls are combinational so the counter halts exactly on a bound.
  always_comb begin
    cnt_enable  = 1'b0;
    cnt_up_down = 1'b1;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    case (state)
      ST_SEEK: begin
        cnt_enable  = !at_lo;
        cnt_up_down = (cnt_value < lo_r);
      end
      ST_UP: begin
        cnt_enable  = !at_hi;
        cnt_up_down = 1'b1;
        tmr_load    = at_hi;
      end
      ST_HOLD_HI: begin
        cnt_up_down = 1'b0;
        tmr_dec     = 1'b1;
      end
      ST_DOWN: begin
        cnt_enable  = !at_lo;
        cnt_up_down = 1'b0;
        tmr_load    = at_lo;
      end
      ST_HOLD_LO: begin
        cnt_up_down = 1'b1;
        tmr_dec     = 1'b1;
      end
      default: begin
        cnt_enable  = 1'b0;
        cnt_up_down = 1'b1;
      end
    endcase
    if (stop && (state != ST_IDLE)) begin
      cnt_enable = 1'b0;
    end
  end

  // Loaded with hold-1 so the dwell state lasts exactly hold cycles.
  sweep_hold_timer #(
    .HOLD_W(HOLD_W)
  ) u_hold_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (hold_r - HOLD_W'(1)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      sweep_cnt  <= '0;
      lo_r       <= '0;
      hi_r       <= '0;
      hold_r     <= '0;
      n_sweeps_r <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (stop && (state != ST_IDLE)) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !stop) begin
              if (lo < hi) begin
                lo_r       <= lo;
                hi_r       <= hi;
                hold_r     <= hold;
                n_sweeps_r <= n_sweeps;
                sweep_cnt  <= '0;
                state      <= ST_SEEK;
                busy       <= 1'b1;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          ST_SEEK: begin
            if (at_lo) state <= ST_UP;
          end
          ST_UP: begin
            if (at_hi) state <= (hold_r == '0) ? ST_DOWN : ST_HOLD_HI;
          end
          ST_HOLD_HI: begin
            if (tmr_zero) state <= ST_DOWN;
          end
          ST_DOWN: begin
            if (at_lo) begin
              sweep_cnt <= sweep_next;
              if ((n_sweeps_r != '0) && (sweep_next == n_sweeps_r)) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= (hold_r == '0) ? ST_UP : ST_HOLD_LO;
              end
            end
          end
          ST_HOLD_LO: begin
            if (tmr_zero) state <= ST_UP;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl cross-connected to up_down_counter.
module tb_updown_sweep_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] hold;
  logic [7:0] n_sweeps;
  logic [3:0] cnt_value;
  logic       cnt_enable;
  logic       cnt_up_down;
  logic       busy;
  logic       done;
  logic       cfg_err;
  logic [7:0] sweep_cnt;

  int passed;
  int total;

  updown_sweep_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .lo          (lo),
    .hi          (hi),
    .hold        (hold),
    .n_sweeps    (n_sweeps),
    .cnt_value   (cnt_value),
    .cnt_enable  (cnt_enable),
    .cnt_up_down (cnt_up_down),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .sweep_cnt   (sweep_cnt)
  );

  up_down_counter #(.WIDTH(4)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (cnt_enable),
    .up_down (cnt_up_down),
    .count   (cnt_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
    logic       stop;
    logic       exp_err;
    logic       exp_busy;
  } cfg_vec_t;

  cfg_vec_t vecs [5];

  // Expected count per cycle for lo=2, hi=5, hold=1, n_sweeps=2 from count 0.
  int exp_seq1 [22] = '{0,1,2, 2,3,4,5, 5, 5,4,3,2, 2, 2,3,4,5, 5, 5,4,3,2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic launch(input int l, input int h, input int hd, input int n);
    lo = 4'(l); hi = 4'(h); hold = 4'(hd); n_sweeps = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int  done_seen;
    bit  ok;
    passed = 0; total = 0;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0;
    lo = '0; hi = '0; hold = '0; n_sweeps = '0;

    // Reset values
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_en", cnt_enable, 0);
    chk("rst_ud", cnt_up_down, 1);
    chk("rst_sweep", sweep_cnt, 0);
    reset_n = 1'b1;
    tick();

    // Basic sweep with dwell, two round trips
    launch(2, 5, 1, 2);
    chk("t1_busy_rise", busy, 1);
    done_seen = 0;
    for (int i = 0; i < 22; i++) begin
      chk($sformatf("t1_cnt[%0d]", i), cnt_value, exp_seq1[i]);
      if (done) done_seen++;
      if (i < 2) chk($sformatf("t1_seek_en[%0d]", i), cnt_enable, 1);
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_busy_fall", busy, 0);
    chk("t1_sweep_cnt", sweep_cnt, 2);
    chk("t1_cnt_end", cnt_value, 2);
    chk("t1_done_early", done_seen, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // Full range, no dwell: 32-cycle period, no wrap
    launch(0, 15, 0, 1);
    tick(); tick(); tick();
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("t2_cnt[%0d]", i), cnt_value, (i < 16) ? i : 31 - i);
      chk($sformatf("t2_ud[%0d]", i), cnt_up_down, (i < 16) ? 1 : 0);
      tick();
    end
    chk("t2_done", done, 1);
    chk("t2_cnt_end", cnt_value, 0);

    // Start acceptance table
    vecs[0] = '{lo: 4'd7, hi: 4'd7, stop: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[1] = '{lo: 4'd9, hi: 4'd3, stop: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[2] = '{lo: 4'd2, hi: 4'd5, stop: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
    vecs[3] = '{lo: 4'd7, hi: 4'd7, stop: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
    vecs[4] = '{lo: 4'd3, hi: 4'd4, stop: 1'b0, exp_err: 1'b0, exp_busy: 1'b1};
    for (int v = 0; v < 5; v++) begin
      lo = vecs[v].lo; hi = vecs[v].hi; hold = 4'd0; n_sweeps = 8'd1;
      start = 1'b1; stop = vecs[v].stop;
      tick();
      start = 1'b0; stop = 1'b0;
      chk($sformatf("tab%0d_err", v), cfg_err, vecs[v].exp_err);
      chk($sformatf("tab%0d_busy", v), busy, vecs[v].exp_busy);
      tick();
      chk($sformatf("tab%0d_err_pulse", v), cfg_err, 0);
      chk($sformatf("tab%0d_busy2", v), busy, vecs[v].exp_busy);
      if (busy) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk($sformatf("tab%0d_stopped", v), busy, 0);
      end
    end

    // Continuous mode, stop mid-UP at count 3 after 3 round trips
    launch(1, 4, 0, 0);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (sweep_cnt == 8'd3) ok = 1'b1;
      else tick();
    end
    chk("t4_reach3", ok, 1);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (cnt_enable && cnt_up_down && cnt_value == 4'd3) ok = 1'b1;
      else tick();
    end
    chk("t4_up_at3", ok, 1);
    stop = 1'b1;
    #1;
    chk("t4_stop_en", cnt_enable, 0);
    tick();
    stop = 1'b0;
    chk("t4_cnt_hold", cnt_value, 3);
    chk("t4_busy", busy, 0);
    chk("t4_no_done", done, 0);
    chk("t4_sweep_cnt", sweep_cnt, 3);

    // Saturation of sweep_cnt in continuous mode
    launch(0, 1, 0, 0);
    repeat (1100) tick();
    chk("t5_sat", sweep_cnt, 255);
    chk("t5_busy", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Reset mid-DOWN at count 4
    launch(1, 6, 0, 1);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (cnt_enable && !cnt_up_down && cnt_value == 4'd4) ok = 1'b1;
      else tick();
    end
    chk("t6_down_at4", ok, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_en", cnt_enable, 0);
    chk("t6_rst_ud", cnt_up_down, 1);
    chk("t6_rst_sweep", sweep_cnt, 0);
    chk("t6_rst_done", done, 0);
    #2;
    reset_n = 1'b1;
    tick();
    lo = 4'd2; hi = 4'd5; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("t6_startstop_busy", busy, 0);
    chk("t6_startstop_err", cfg_err, 0);

    // Park counter at 12, then SEEK downward to lo=3
    launch(12, 13, 0, 1);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      if (done) ok = 1'b1;
      else tick();
    end
    chk("t7_park_done", ok, 1);
    chk("t7_park_cnt", cnt_value, 12);
    tick();
    launch(3, 6, 0, 1);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t7_seek_cnt[%0d]", i), cnt_value, 12 - i);
      chk($sformatf("t7_seek_ud[%0d]", i), cnt_up_down, 0);
      chk($sformatf("t7_seek_en[%0d]", i), cnt_enable, 1);
      tick();
    end
    chk("t7_seek_end_cnt", cnt_value, 3);
    chk("t7_seek_end_en", cnt_enable, 0);
    tick();
    chk("t7_up_ud", cnt_up_down, 1);
    chk("t7_up_en", cnt_enable, 1);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (done) ok = 1'b1;
      else tick();
    end
    chk("t7_done", ok, 1);
    chk("t7_sweep_cnt", sweep_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
